// File: rtl/ble_pkg.sv
// Shared types and default timing constants for the BLE link supervisor.
package ble_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } sup_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 25_000_000;
  localparam int DEF_SLEW_DIV       = 100_000;
  localparam int DEF_SLEW_STEP      = 1;
  localparam int DEF_ARM_COUNT      = 3;

endpackage

// File: rtl/ble_slew_limiter.sv
// Rate-limits an 8-bit unsigned setpoint toward its target by at most SLEW_STEP per tick.
// One-cycle registered update; output clears to 0 whenever en is low; no backpressure.
module ble_slew_limiter import ble_pkg::*; #(
  parameter int SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic [7:0] target,
  output logic [7:0] cmd
);

  // A step wider than the byte range can never be taken in full.
  localparam logic [7:0] STEP8 = (SLEW_STEP > 255) ? 8'd255 : 8'(SLEW_STEP);

  logic [7:0] up;
  logic [7:0] dn;

  assign up = target - cmd;
  assign dn = cmd - target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd <= '0;
    end else if (!en) begin
      cmd <= '0;
    end else if (tick) begin
      if (target > cmd) begin
        cmd <= (up > STEP8) ? cmd + STEP8 : target;
      end else if (cmd > target) begin
        cmd <= (dn > STEP8) ? cmd - STEP8 : target;
      end
    end
  end

endmodule

// File: rtl/ble_link_supervisor.sv
// Arming/failsafe supervisor for BLE command packets: gain latching, link timeout, slewed setpoints.
// All outputs registered, one cycle after the packet strobe; no backpressure, packets always accepted.
module ble_link_supervisor import ble_pkg::*; #(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SLEW_DIV       = DEF_SLEW_DIV,
  parameter int SLEW_STEP      = DEF_SLEW_STEP,
  parameter int ARM_COUNT      = DEF_ARM_COUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vector_valid,
  input  logic [7:0] initialize_mpu_motor,
  input  logic [7:0] initialize_mpu,
  input  logic [7:0] ble_set_pitch,
  input  logic [7:0] ble_set_yaw,
  input  logic [7:0] ble_pitch_kP,
  input  logic [7:0] ble_pitch_kI,
  input  logic [7:0] ble_pitch_kD,
  input  logic [7:0] ble_yaw_kP,
  input  logic [7:0] ble_yaw_kI,
  input  logic [7:0] ble_yaw_kD,
  output logic [7:0] pitch_kP,
  output logic [7:0] pitch_kI,
  output logic [7:0] pitch_kD,
  output logic [7:0] yaw_kP,
  output logic [7:0] yaw_kI,
  output logic [7:0] yaw_kD,
  output logic [7:0] set_pitch_cmd,
  output logic [7:0] set_yaw_cmd,
  output logic       motor_enable,
  output logic       mpu_init_pulse,
  output logic       link_ok,
  output logic [1:0] sup_state
);

  localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int              DW      = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0]   DMAX    = DW'(SLEW_DIV - 1);
  localparam logic [7:0]      ARM_MAX = 8'(ARM_COUNT);

  sup_state_t    state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [DW-1:0] div;
  logic [7:0]    arm_cnt, arm_cnt_n;
  logic [7:0]    pitch_tgt, yaw_tgt;
  logic          seen, prev_init, tick, timeout, qual, armed_n;
  logic          unused_init_bits;

  assign unused_init_bits = ^initialize_mpu[7:1];

  assign qual    = vector_valid && (initialize_mpu_motor != 8'd0) &&
                   (ble_set_pitch == 8'd0) && (ble_set_yaw == 8'd0);
  assign tcnt_n  = vector_valid ? '0 : ((tcnt == TMAX) ? tcnt : tcnt + 1'b1);
  // Timeout is judged on the counter value being written, so a packet on that edge always wins.
  assign timeout = (tcnt_n == TMAX);
  assign tick    = (div == DMAX);
  assign armed_n = (state_n == ARMED);
  assign sup_state = state;

  always_comb begin
    state_n   = state;
    arm_cnt_n = arm_cnt;
    if (timeout && (state == ARMING || state == ARMED)) begin
      state_n   = FAILSAFE;
      arm_cnt_n = '0;
    end else if (vector_valid) begin
      case (state)
        DISARMED: if (qual) begin
          arm_cnt_n = 8'd1;
          state_n   = (ARM_MAX <= 8'd1) ? ARMED : ARMING;
        end
        ARMING: if (qual) begin
          arm_cnt_n = arm_cnt + 8'd1;
          if (arm_cnt_n >= ARM_MAX) state_n = ARMED;
        end else begin
          arm_cnt_n = '0;
          state_n   = DISARMED;
        end
        ARMED: if (initialize_mpu_motor == 8'd0) begin
          arm_cnt_n = '0;
          state_n   = DISARMED;
        end
        FAILSAFE: if (initialize_mpu_motor == 8'd0) state_n = DISARMED;
        default: state_n = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DISARMED;
      arm_cnt        <= '0;
      tcnt           <= '0;
      div            <= '0;
      seen           <= 1'b0;
      prev_init      <= 1'b0;
      link_ok        <= 1'b0;
      motor_enable   <= 1'b0;
      mpu_init_pulse <= 1'b0;
      pitch_tgt      <= '0;
      yaw_tgt        <= '0;
      pitch_kP       <= '0;
      pitch_kI       <= '0;
      pitch_kD       <= '0;
      yaw_kP         <= '0;
      yaw_kI         <= '0;
      yaw_kD         <= '0;
    end else begin
      state          <= state_n;
      arm_cnt        <= arm_cnt_n;
      tcnt           <= tcnt_n;
      div            <= tick ? '0 : div + 1'b1;
      link_ok        <= (seen || vector_valid) && (tcnt_n < TMAX);
      motor_enable   <= armed_n;
      mpu_init_pulse <= vector_valid && initialize_mpu[0] && !prev_init;
      if (vector_valid) begin
        seen      <= 1'b1;
        prev_init <= initialize_mpu[0];
      end
      if (vector_valid && state != FAILSAFE) begin
        pitch_kP <= ble_pitch_kP;
        pitch_kI <= ble_pitch_kI;
        pitch_kD <= ble_pitch_kD;
        yaw_kP   <= ble_yaw_kP;
        yaw_kI   <= ble_yaw_kI;
        yaw_kD   <= ble_yaw_kD;
      end
      if (!armed_n) begin
        pitch_tgt <= '0;
        yaw_tgt   <= '0;
      end else if (vector_valid && state == ARMED) begin
        pitch_tgt <= ble_set_pitch;
        yaw_tgt   <= ble_set_yaw;
      end
    end
  end

  // Limiters see the pre-update target, and are cleared as soon as ARMED is left.
  ble_slew_limiter #(.SLEW_STEP(SLEW_STEP)) u_pitch_slew (
    .clk(clk), .rst(rst), .en(armed_n), .tick(tick), .target(pitch_tgt), .cmd(set_pitch_cmd)
  );

  ble_slew_limiter #(.SLEW_STEP(SLEW_STEP)) u_yaw_slew (
    .clk(clk), .rst(rst), .en(armed_n), .tick(tick), .target(yaw_tgt), .cmd(set_yaw_cmd)
  );

endmodule

// File: doc/ble_link_supervisor.md
BLE_LINK_SUPERVISOR -- requirements
Module: ble_link_supervisor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25_000_000, meaning cycles without a valid packet before link loss (250 ms at 100 MHz).
REQ-002 SHALL have parameter SLEW_DIV, default 100_000, meaning cycles per slew tick.
REQ-003 SHALL have parameter SLEW_STEP, default 1, meaning maximum setpoint change per tick.
REQ-004 SHALL have parameter ARM_COUNT, default 3, meaning consecutive qualifying packets needed to arm.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port vector_valid  input  1  one-cycle strobe; the command bytes below are valid this cycle.
REQ-008 SHALL have ports initialize_mpu_motor, initialize_mpu, ble_set_pitch, ble_set_yaw  input  8 each  command bytes.
REQ-009 SHALL have ports ble_pitch_kP/kI/kD, ble_yaw_kP/kI/kD  input  8 each  gain bytes.
REQ-010 SHALL have ports pitch_kP/kI/kD, yaw_kP/kI/kD  output  8 each  applied gains.
REQ-011 SHALL have ports set_pitch_cmd, set_yaw_cmd  output  8 each  slewed setpoints, unsigned.
REQ-012 SHALL have port motor_enable  output  1  high only in ARMED.
REQ-013 SHALL have port mpu_init_pulse  output  1  one-cycle MPU init request.
REQ-014 SHALL have port link_ok  output  1  packet seen since reset and no timeout.
REQ-015 SHALL have port sup_state  output  2  current state encoding.

Function
REQ-016 SHALL implement the states DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.
REQ-017 SHALL define a qualifying packet as: vector_valid, initialize_mpu_motor!=0, ble_set_pitch==0, ble_set_yaw==0.
REQ-018 SHALL transition DISARMED->ARMING on a qualifying packet and set arm_cnt=1.
REQ-019 SHALL, in ARMING, increment arm_cnt on each qualifying packet and enter ARMED when arm_cnt reaches ARM_COUNT.
REQ-020 SHALL, in ARMING, return to DISARMED on any non-qualifying packet.
REQ-021 SHALL transition ARMED->DISARMED on a packet with initialize_mpu_motor==0.
REQ-022 SHALL enter FAILSAFE from ARMING or ARMED on timeout.
REQ-023 SHALL leave FAILSAFE only to DISARMED, on a packet with initialize_mpu_motor==0; other packets are ignored.
REQ-024 SHALL clear the timeout counter on vector_valid and otherwise increment it, saturating at TIMEOUT_CYCLES.
REQ-025 SHALL treat the link as timed out when the counter equals TIMEOUT_CYCLES.
REQ-026 SHALL give priority to the packet when vector_valid coincides with counter reaching TIMEOUT_CYCLES: no FAILSAFE entry.
REQ-027 SHALL drive link_ok = seen_packet AND (counter < TIMEOUT_CYCLES).
REQ-028 SHALL latch the gain outputs from a valid packet one cycle after vector_valid, in any state except FAILSAFE.
REQ-029 SHALL latch pitch and yaw targets from valid packets in ARMED only, and force both targets to 0 in all other states.
REQ-030 SHALL force set_pitch_cmd and set_yaw_cmd to 0 in the cycle after leaving ARMED.
REQ-031 SHALL generate a slew tick once every SLEW_DIV cycles from a free-running divider.
REQ-032 SHALL, on each tick in ARMED, move each command toward its target by min(SLEW_STEP, |target-cmd|), with no overshoot and no wrap-around.
REQ-033 SHALL use the pre-update target for a tick that coincides with a packet.
REQ-034 SHALL pulse mpu_init_pulse for one cycle, one cycle after a packet whose initialize_mpu[0]=1 when the previous packet's initialize_mpu[0] was 0; the previous value is 0 after reset.
REQ-035 SHALL register every output, with no combinational input-to-output path.

Reset
REQ-036 SHALL, on rst, asynchronously set state=DISARMED, all gains 0, both commands 0, both targets 0, motor_enable 0, mpu_init_pulse 0, link_ok 0, arm_cnt 0, timeout counter 0, divider 0, seen_packet 0.
REQ-037 SHALL, on rst asserted mid-slew or while ARMED, drop motor_enable in the same cycle as rst asserts, before the next clock edge.

Structure
REQ-038 SHALL place the sup_state_t enum and the default parameter constants in shared package ble_pkg.
REQ-039 SHALL implement slew limiting in sub-module ble_slew_limiter, instantiated twice (pitch, yaw).

Verification (TIMEOUT_CYCLES=1000, SLEW_DIV=4, SLEW_STEP=1, ARM_COUNT=3)
REQ-040 SHALL cover: three packets with motor=1, pitch=0, yaw=0 -> sup_state 0->1->1->2, with motor_enable=1 one cycle after the third packet.
REQ-041 SHALL cover: in ARMED, a packet with pitch=10 -> set_pitch_cmd steps 0,1,...,10 at one step per 4 cycles, then holds at 10; a following packet with pitch=7 -> steps down to 7 only.
REQ-042 SHALL cover: in ARMED, no packets for 1000 cycles -> link_ok=0, sup_state=3, motor_enable=0, commands=0; then a packet with motor=1 -> stays in FAILSAFE; a packet with motor=0 -> DISARMED.
REQ-043 SHALL cover: a packet with initialize_mpu=1 after one with initialize_mpu=0 -> exactly one mpu_init_pulse; a repeated packet with initialize_mpu=1 -> no pulse.
REQ-044 SHALL cover: a packet on the exact cycle the counter hits 1000 -> sup_state remains ARMED and link_ok stays 1.
REQ-045 SHALL cover: two qualifying packets, then one with pitch=5 -> DISARMED, with gains updated to the values in that packet.
